// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_if
//  Description : Read handshake bundle between the memory stage and the data
//                memory. The stage (master) raises rd_req with a stable
//                rd_addr. Memory (slave) answers with rd_ack and rd_data in
//                the cycle the data is valid.
//  Signals     : rd_req  - read request        (master -> slave)
//                rd_addr - 16-bit read address (master -> slave)
//                rd_ack  - read data valid     (slave  -> master)
//                rd_data - 16-bit read data    (slave  -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic        rd_ack;
  logic [15:0] rd_data;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_ack,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_ack,
    output rd_data
  );
endinterface : mem_stage_if
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Memory stage of the 5-stage pipeline. Non-load instructions
//                pass through with one cycle of latency. Loads use a
//                variable-latency read handshake. The front of the pipeline
//                is stalled while a load is outstanding. A load that is not
//                acknowledged within TIMEOUT wait cycles is retired with
//                ERR_DATA and raises the sticky bus_err flag.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                ex_*                  - execute-stage registered outputs
//                halt_in_wb            - writeback halted, kill this stage
//                mem_bus               - read handshake (master side)
//                stall_out             - hold pc/decode/execute this cycle
//                mem_*_out, mem_tgt    - writeback slot and forwarding value
//                bus_err               - sticky load-timeout flag
//                load_cnt, stall_cnt   - saturating event counters
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int          TIMEOUT  = 255,
  parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic [15:0] ex_result,
  input  wire logic [2:0]  ex_opcode,
  input  wire logic [2:0]  ex_tgt,
  input  wire logic        ex_bubble,
  input  wire logic        ex_halt,
  input  wire logic        halt_in_wb,
  mem_stage_if.master      mem_bus,
  output logic             stall_out,
  output logic [15:0]      mem_result_out,
  output logic [2:0]       mem_tgt,
  output logic [2:0]       mem_opcode_out,
  output logic             mem_bubble_out,
  output logic             mem_halt_out,
  output logic             bus_err,
  output logic [15:0]      load_cnt,
  output logic [15:0]      stall_cnt
);

  localparam logic [2:0]  OP_LOAD  = 3'b101;
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;
  // Wait counter counts 0 .. TIMEOUT-1
  localparam int          WCW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]     state_q,    state_d;
  logic [15:0]    addr_q,     addr_d;
  logic [2:0]     hold_tgt_q, hold_tgt_d;
  logic [2:0]     hold_opc_q, hold_opc_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [15:0]    result_q,   result_d;
  logic [2:0]     tgt_q,      tgt_d;
  logic [2:0]     opc_q,      opc_d;
  logic           bubble_q,   bubble_d;
  logic           halt_q,     halt_d;
  logic           bus_err_q,  bus_err_d;
  logic [15:0]    load_cnt_q;
  logic [15:0]    stall_cnt_q;

  logic           w_rd_req;
  logic [15:0]    w_rd_addr;
  logic           w_stall;
  logic           w_load_done;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    hold_tgt_d  = hold_tgt_q;
    hold_opc_d  = hold_opc_q;
    wait_cnt_d  = wait_cnt_q;
    result_d    = result_q;
    tgt_d       = tgt_q;
    opc_d       = opc_q;
    bubble_d    = bubble_q;
    halt_d      = halt_q;
    bus_err_d   = bus_err_q;
    w_rd_req    = 1'b0;
    w_rd_addr   = ex_result;
    w_stall     = 1'b0;
    w_load_done = 1'b0;

    if (halt_in_wb) begin
      // Kill: drop any outstanding request; a late ack lands in IDLE with
      // rd_req low and is therefore ignored.
      state_d  = S_IDLE;
      tgt_d    = 3'd0;
      bubble_d = 1'b1;
      halt_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!ex_bubble && ex_opcode == OP_LOAD) begin
            w_rd_req  = 1'b1;
            w_rd_addr = ex_result;
            if (mem_bus.rd_ack) begin
              result_d    = mem_bus.rd_data;
              tgt_d       = ex_tgt;
              opc_d       = ex_opcode;
              bubble_d    = 1'b0;
              halt_d      = 1'b0;
              w_load_done = 1'b1;
            end else begin
              w_stall    = 1'b1;
              state_d    = S_WAIT;
              addr_d     = ex_result;
              hold_tgt_d = ex_tgt;
              hold_opc_d = ex_opcode;
              wait_cnt_d = '0;
              tgt_d      = 3'd0;
              bubble_d   = 1'b1;
              halt_d     = 1'b0;
            end
          end else begin
            result_d = ex_result;
            // A bubble never carries a target, so execute cannot forward it
            tgt_d    = ex_bubble ? 3'd0 : ex_tgt;
            opc_d    = ex_opcode;
            bubble_d = ex_bubble;
            halt_d   = ex_halt && !ex_bubble;
          end
        end

        S_WAIT: begin
          w_rd_req  = 1'b1;
          w_rd_addr = addr_q;
          if (mem_bus.rd_ack) begin
            result_d    = mem_bus.rd_data;
            tgt_d       = hold_tgt_q;
            opc_d       = hold_opc_q;
            bubble_d    = 1'b0;
            halt_d      = 1'b0;
            w_load_done = 1'b1;
            state_d     = S_IDLE;
          end else if (wait_cnt_q == WAIT_LAST) begin
            // Abort retires the load, so upstream is released this cycle
            // just as on an ack; otherwise the held load would be reissued.
            result_d  = ERR_DATA;
            tgt_d     = hold_tgt_q;
            opc_d     = hold_opc_q;
            bubble_d  = 1'b0;
            halt_d    = 1'b0;
            bus_err_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            w_stall    = 1'b1;
            wait_cnt_d = wait_cnt_q + 1'b1;
            tgt_d      = 3'd0;
            bubble_d   = 1'b1;
            halt_d     = 1'b0;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= 16'd0;
      hold_tgt_q  <= 3'd0;
      hold_opc_q  <= 3'd0;
      wait_cnt_q  <= '0;
      result_q    <= 16'd0;
      tgt_q       <= 3'd0;
      opc_q       <= 3'd0;
      bubble_q    <= 1'b1;
      halt_q      <= 1'b0;
      bus_err_q   <= 1'b0;
      load_cnt_q  <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      hold_tgt_q <= hold_tgt_d;
      hold_opc_q <= hold_opc_d;
      wait_cnt_q <= wait_cnt_d;
      result_q   <= result_d;
      tgt_q      <= tgt_d;
      opc_q      <= opc_d;
      bubble_q   <= bubble_d;
      halt_q     <= halt_d;
      bus_err_q  <= bus_err_d;
      if (w_load_done && load_cnt_q != CNT_MAX) begin
        load_cnt_q <= load_cnt_q + 16'd1;
      end
      if (w_stall && stall_cnt_q != CNT_MAX) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  // Handshake and stall are forced low while reset is asserted
  assign mem_bus.rd_req  = w_rd_req && !rst;
  assign mem_bus.rd_addr = w_rd_addr;
  assign stall_out       = w_stall && !rst;

  assign mem_result_out  = result_q;
  assign mem_tgt         = tgt_q;
  assign mem_opcode_out  = opc_q;
  assign mem_bubble_out  = bubble_q;
  assign mem_halt_out    = halt_q;
  assign bus_err         = bus_err_q;
  assign load_cnt        = load_cnt_q;
  assign stall_cnt       = stall_cnt_q;

endmodule : mem_stage
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage (TIMEOUT = 4). Directed
//                scenarios plus a randomized instruction stream scored
//                against a per-instruction latency model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  localparam int          TIMEOUT  = 4;
  localparam logic [15:0] ERR_DATA = 16'hDEAD;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ex_result;
  logic [2:0]  ex_opcode;
  logic [2:0]  ex_tgt;
  logic        ex_bubble;
  logic        ex_halt;
  logic        halt_in_wb;
  logic        stall_out;
  logic [15:0] mem_result_out;
  logic [2:0]  mem_tgt;
  logic [2:0]  mem_opcode_out;
  logic        mem_bubble_out;
  logic        mem_halt_out;
  logic        bus_err;
  logic [15:0] load_cnt;
  logic [15:0] stall_cnt;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_result      (ex_result),
    .ex_opcode      (ex_opcode),
    .ex_tgt         (ex_tgt),
    .ex_bubble      (ex_bubble),
    .ex_halt        (ex_halt),
    .halt_in_wb     (halt_in_wb),
    .mem_bus        (bus),
    .stall_out      (stall_out),
    .mem_result_out (mem_result_out),
    .mem_tgt        (mem_tgt),
    .mem_opcode_out (mem_opcode_out),
    .mem_bubble_out (mem_bubble_out),
    .mem_halt_out   (mem_halt_out),
    .bus_err        (bus_err),
    .load_cnt       (load_cnt),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model-side bookkeeping for the whole run
  int unsigned exp_loads  = 0;
  int unsigned exp_stalls = 0;
  logic        exp_err    = 1'b0;

  // Registered outputs are read 1 ns after the edge; inputs change then too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    ex_result  = 16'd0;
    ex_opcode  = 3'd0;
    ex_tgt     = 3'd0;
    ex_bubble  = 1'b1;
    ex_halt    = 1'b0;
    halt_in_wb = 1'b0;
    bus.rd_ack  = 1'b0;
    bus.rd_data = 16'd0;
  endtask

  task automatic drive_load(input logic [15:0] addr, input logic [2:0] tgt);
    ex_result = addr;
    ex_opcode = 3'b101;
    ex_tgt    = tgt;
    ex_bubble = 1'b0;
    ex_halt   = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    drive_load(16'h0055, 3'd1);
    tick();
    #2;
    checks++;
    if ({bus.rd_req, stall_out} !== 2'b00)
      $display("FAIL reset_comb: rd_req/stall=%b want 00", {bus.rd_req, stall_out});
    else passes++;
    tick();
    checks++;
    if ({mem_result_out, mem_tgt, mem_opcode_out, mem_bubble_out, mem_halt_out, bus_err}
        !== {16'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_regs: res=%h tgt=%0d opc=%0d bub=%b halt=%b err=%b",
               mem_result_out, mem_tgt, mem_opcode_out, mem_bubble_out, mem_halt_out, bus_err);
    else passes++;
    checks++;
    if ({load_cnt, stall_cnt} !== 32'd0)
      $display("FAIL reset_cnt: load_cnt=%0d stall_cnt=%0d want 0 0", load_cnt, stall_cnt);
    else passes++;
    rst = 1'b0;
    set_idle();
    exp_loads = 0; exp_stalls = 0; exp_err = 1'b0;
    tick();
  endtask

  task automatic test_passthrough();
    ex_opcode = 3'b000; ex_result = 16'h1234; ex_tgt = 3'd3; ex_bubble = 1'b0;
    #2;
    checks++;
    if ({bus.rd_req, stall_out} !== 2'b00)
      $display("FAIL pass_comb: rd_req/stall=%b want 00", {bus.rd_req, stall_out});
    else passes++;
    tick();
    checks++;
    if ({mem_result_out, mem_tgt, mem_bubble_out, mem_opcode_out} !== {16'h1234, 3'd3, 1'b0, 3'd0})
      $display("FAIL pass_regs: res=%h tgt=%0d bub=%b opc=%0d want 1234 3 0 0",
               mem_result_out, mem_tgt, mem_bubble_out, mem_opcode_out);
    else passes++;
    set_idle();
  endtask

  task automatic test_zero_wait();
    drive_load(16'h0040, 3'd5);
    bus.rd_ack = 1'b1; bus.rd_data = 16'hBEEF;
    #2;
    checks++;
    if ({bus.rd_req, bus.rd_addr, stall_out} !== {1'b1, 16'h0040, 1'b0})
      $display("FAIL zw_comb: rd_req=%b rd_addr=%h stall=%b want 1 0040 0",
               bus.rd_req, bus.rd_addr, stall_out);
    else passes++;
    tick();
    exp_loads++;
    checks++;
    if ({mem_result_out, mem_tgt, mem_bubble_out, load_cnt} !== {16'hBEEF, 3'd5, 1'b0, 16'(exp_loads)})
      $display("FAIL zw_regs: res=%h tgt=%0d bub=%b load_cnt=%0d want BEEF 5 0 %0d",
               mem_result_out, mem_tgt, mem_bubble_out, load_cnt, exp_loads);
    else passes++;
    set_idle();
  endtask

  task automatic test_latency3();
    logic [15:0] addr, data;
    addr = 16'($urandom); data = 16'($urandom);
    drive_load(addr, 3'd2);
    bus.rd_data = data;
    for (int k = 1; k <= 3; k++) begin
      bus.rd_ack = (k == 3);
      #2;
      checks++;
      if ({bus.rd_req, bus.rd_addr, stall_out} !== {1'b1, addr, (k < 3)})
        $display("FAIL lat3_comb%0d: rd_req=%b rd_addr=%h stall=%b want 1 %h %b",
                 k, bus.rd_req, bus.rd_addr, stall_out, addr, (k < 3));
      else passes++;
      tick();
      if (k < 3) begin
        checks++;
        if ({mem_bubble_out, mem_tgt} !== {1'b1, 3'd0})
          $display("FAIL lat3_bubble%0d: bub=%b tgt=%0d want 1 0", k, mem_bubble_out, mem_tgt);
        else passes++;
      end
    end
    exp_loads++; exp_stalls += 2;
    checks++;
    if ({mem_result_out, mem_tgt, mem_bubble_out, stall_cnt, load_cnt}
        !== {data, 3'd2, 1'b0, 16'(exp_stalls), 16'(exp_loads)})
      $display("FAIL lat3_result: res=%h tgt=%0d bub=%b stall_cnt=%0d load_cnt=%0d want %h 2 0 %0d %0d",
               mem_result_out, mem_tgt, mem_bubble_out, stall_cnt, load_cnt, data, exp_stalls, exp_loads);
    else passes++;
    set_idle();
  endtask

  task automatic test_timeout();
    drive_load(16'h0100, 3'd4);
    // One IDLE request cycle plus TIMEOUT wait cycles, none acknowledged
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      #2;
      checks++;
      if ({bus.rd_req, stall_out} !== {1'b1, (k <= TIMEOUT)})
        $display("FAIL to_comb%0d: rd_req=%b stall=%b want 1 %b", k, bus.rd_req, stall_out, (k <= TIMEOUT));
      else passes++;
      tick();
    end
    exp_stalls += TIMEOUT; exp_err = 1'b1;
    checks++;
    if ({mem_result_out, mem_tgt, mem_bubble_out, bus_err, load_cnt}
        !== {ERR_DATA, 3'd4, 1'b0, 1'b1, 16'(exp_loads)})
      $display("FAIL to_result: res=%h tgt=%0d bub=%b err=%b load_cnt=%0d want DEAD 4 0 1 %0d",
               mem_result_out, mem_tgt, mem_bubble_out, bus_err, load_cnt, exp_loads);
    else passes++;
    set_idle();
    #2;
    checks++;
    if (bus.rd_req !== 1'b0)
      $display("FAIL to_req_drop: rd_req=%b want 0", bus.rd_req);
    else passes++;
    tick();
    drive_load(16'h0200, 3'd6);
    bus.rd_ack = 1'b1; bus.rd_data = 16'h1111;
    tick();
    exp_loads++;
    checks++;
    if ({mem_result_out, mem_tgt, bus_err, load_cnt} !== {16'h1111, 3'd6, 1'b1, 16'(exp_loads)})
      $display("FAIL to_after: res=%h tgt=%0d err=%b load_cnt=%0d want 1111 6 1 %0d",
               mem_result_out, mem_tgt, bus_err, load_cnt, exp_loads);
    else passes++;
    set_idle();
  endtask

  task automatic test_kill();
    drive_load(16'h0300, 3'd7);
    tick();          // IDLE request, no ack
    tick();          // first wait cycle, no ack
    halt_in_wb = 1'b1;
    ex_halt    = 1'b1;
    #2;
    checks++;
    if ({bus.rd_req, stall_out} !== 2'b00)
      $display("FAIL kill_comb: rd_req/stall=%b want 00", {bus.rd_req, stall_out});
    else passes++;
    tick();
    exp_stalls += 2;
    checks++;
    if ({mem_bubble_out, mem_tgt, mem_halt_out} !== {1'b1, 3'd0, 1'b0})
      $display("FAIL kill_regs: bub=%b tgt=%0d halt=%b want 1 0 0", mem_bubble_out, mem_tgt, mem_halt_out);
    else passes++;
    set_idle();
    bus.rd_ack = 1'b1; bus.rd_data = 16'h7777;
    #2;
    checks++;
    if (bus.rd_req !== 1'b0)
      $display("FAIL kill_idle_req: rd_req=%b want 0", bus.rd_req);
    else passes++;
    tick();
    checks++;
    if ({mem_bubble_out, mem_tgt, load_cnt, stall_cnt} !== {1'b1, 3'd0, 16'(exp_loads), 16'(exp_stalls)})
      $display("FAIL kill_late_ack: bub=%b tgt=%0d load_cnt=%0d stall_cnt=%0d want 1 0 %0d %0d",
               mem_bubble_out, mem_tgt, load_cnt, stall_cnt, exp_loads, exp_stalls);
    else passes++;
    set_idle();
  endtask

  task automatic test_reset_mid_wait();
    drive_load(16'h0400, 3'd1);
    tick();
    tick();
    rst = 1'b1;
    #2;
    checks++;
    if ({bus.rd_req, stall_out} !== 2'b00)
      $display("FAIL rstw_comb: rd_req/stall=%b want 00", {bus.rd_req, stall_out});
    else passes++;
    tick();
    rst = 1'b0;
    set_idle();
    exp_loads = 0; exp_stalls = 0; exp_err = 1'b0;
    checks++;
    if ({mem_result_out, mem_tgt, mem_opcode_out, mem_bubble_out, mem_halt_out, bus_err, load_cnt, stall_cnt}
        !== {16'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0})
      $display("FAIL rstw_regs: res=%h tgt=%0d opc=%0d bub=%b halt=%b err=%b lc=%0d sc=%0d",
               mem_result_out, mem_tgt, mem_opcode_out, mem_bubble_out, mem_halt_out,
               bus_err, load_cnt, stall_cnt);
    else passes++;
    bus.rd_ack = 1'b1;
    tick();
    checks++;
    if ({mem_bubble_out, load_cnt} !== {1'b1, 16'd0})
      $display("FAIL rstw_noload: bub=%b load_cnt=%0d want 1 0", mem_bubble_out, load_cnt);
    else passes++;
    set_idle();
  endtask

  task automatic test_bubble_halt();
    ex_halt = 1'b1; ex_bubble = 1'b1; ex_tgt = 3'd3;
    tick();
    checks++;
    if ({mem_halt_out, mem_bubble_out, mem_tgt} !== {1'b0, 1'b1, 3'd0})
      $display("FAIL bh_bubble: halt=%b bub=%b tgt=%0d want 0 1 0", mem_halt_out, mem_bubble_out, mem_tgt);
    else passes++;
    ex_bubble = 1'b0;
    tick();
    checks++;
    if ({mem_halt_out, mem_bubble_out, mem_tgt} !== {1'b1, 1'b0, 3'd3})
      $display("FAIL bh_valid: halt=%b bub=%b tgt=%0d want 1 0 3", mem_halt_out, mem_bubble_out, mem_tgt);
    else passes++;
    set_idle();
    tick();
  endtask

  // Random stream. Model: a load acknowledged on request cycle L retires
  // rd_data after L cycles with L-1 stall cycles, provided L <= TIMEOUT+1;
  // otherwise it retires ERR_DATA after TIMEOUT+1 cycles with TIMEOUT stalls.
  task automatic test_random();
    logic [15:0] addr, data, exp_res;
    logic [2:0]  tgt, op, exp_tgt;
    logic        bub, exp_bub, stalled;
    int          lat, n_stall, want_stall;
    for (int n = 0; n < 40; n++) begin
      addr = 16'($urandom); data = 16'($urandom); tgt = 3'($urandom);
      set_idle();
      if ($urandom_range(0, 1) == 0) begin
        op  = 3'($urandom_range(0, 6));
        if (op >= 3'd5) op = op + 3'd1;
        bub = ($urandom_range(0, 3) == 0);
        ex_result = addr; ex_opcode = op; ex_tgt = tgt; ex_bubble = bub;
        tick();
        exp_res = addr; exp_tgt = bub ? 3'd0 : tgt; exp_bub = bub;
        checks++;
        if ({mem_result_out, mem_tgt, mem_bubble_out, mem_opcode_out} !== {exp_res, exp_tgt, exp_bub, op})
          $display("FAIL rnd_pass%0d: res=%h tgt=%0d bub=%b opc=%0d want %h %0d %b %0d",
                   n, mem_result_out, mem_tgt, mem_bubble_out, mem_opcode_out, exp_res, exp_tgt, exp_bub, op);
        else passes++;
      end else begin
        lat = $urandom_range(1, TIMEOUT + 3);
        drive_load(addr, tgt);
        bus.rd_data = data;
        n_stall = 0;
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
          bus.rd_ack = (k == lat);
          #2;
          checks++;
          if ({bus.rd_req, bus.rd_addr} !== {1'b1, addr})
            $display("FAIL rnd_req%0d_%0d: rd_req=%b rd_addr=%h want 1 %h", n, k, bus.rd_req, bus.rd_addr, addr);
          else passes++;
          stalled = stall_out;
          if (stalled) n_stall++;
          tick();
          if (!stalled) break;
        end
        if (lat <= TIMEOUT + 1) begin
          want_stall = lat - 1; exp_res = data; exp_loads++;
        end else begin
          want_stall = TIMEOUT; exp_res = ERR_DATA; exp_err = 1'b1;
        end
        exp_stalls += want_stall;
        checks++;
        if (n_stall != want_stall)
          $display("FAIL rnd_stalls%0d: stall cycles=%0d want %0d (lat %0d)", n, n_stall, want_stall, lat);
        else passes++;
        checks++;
        if ({mem_result_out, mem_tgt, mem_bubble_out, bus_err, load_cnt, stall_cnt}
            !== {exp_res, tgt, 1'b0, exp_err, 16'(exp_loads), 16'(exp_stalls)})
          $display("FAIL rnd_load%0d: res=%h tgt=%0d bub=%b err=%b lc=%0d sc=%0d want %h %0d 0 %b %0d %0d",
                   n, mem_result_out, mem_tgt, mem_bubble_out, bus_err, load_cnt, stall_cnt,
                   exp_res, tgt, exp_err, exp_loads, exp_stalls);
        else passes++;
      end
    end
    set_idle();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    tick();
    test_reset();
    test_passthrough();
    test_zero_wait();
    test_latency3();
    test_timeout();
    test_kill();
    test_reset_mid_wait();
    test_bubble_halt();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Absolute guard so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passes=%0d checks=%0d", passes, checks);
    $fatal(1);
  end

endmodule : tb_mem_stage
`default_nettype wire
